wb_xbar_decoder: RTL and testbench

- Parametrised 1-master to N-slave Wishbone (WB4) address decoder/router between the CPU data port and peripherals (memory, uart, uart_rx, ...).
- Address map is set by base/mask parameter arrays.
- Adds over the prior fixed-map decoder: registered slave selection held for the whole transfer, an ERR response for unmapped addresses, and a per-transfer timeout watchdog.
- Error status outputs report the faulting address.

---
 rtl/wb_xbar_pkg.sv | 39 +++
 rtl/wb_xbar_decoder_timeout.sv | 28 ++
 rtl/wb_xbar_decoder.sv | 192 +++++++++++++++++++
 tb/tb_wb_xbar_decoder.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_xbar_pkg.sv
// Shared types and the address-match helper for the Wishbone 1:N decoder.
package wb_xbar_pkg;

    localparam int MAX_SLAVES = 16;
    // Widest address the match helper handles; narrower maps are zero-extended.
    localparam int MAX_ADDR_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DECERR = 2'd2,
        TOERR  = 2'd3
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } match_t;

    typedef logic [MAX_ADDR_W-1:0] addr_arr_t [MAX_SLAVES];

    // Returns the lowest-index slave whose (adr & mask) == base. Unused table
    // entries are padded with mask=0/base=all-ones so they can never match.
    function automatic match_t match_idx(input logic [MAX_ADDR_W-1:0] adr,
                                         input addr_arr_t base,
                                         input addr_arr_t mask);
        match_t m;
        m.hit = 1'b0;
        m.idx = '0;
        for (int i = MAX_SLAVES - 1; i >= 0; i--) begin
            if ((adr & mask[i]) == base[i]) begin
                m.hit = 1'b1;
                m.idx = 4'(i);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_xbar_decoder_timeout.sv
// Per-transfer watchdog: counts enabled cycles, flags the last allowed cycle.
module wb_timeout_cnt #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    // Counter only has to reach TIMEOUT_CYC-1 before the FSM leaves ACTIVE.
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_reg;

    // Restart from zero whenever the watched state is not active.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // A zero timeout disables the watchdog entirely.
    assign expire = (TIMEOUT_CYC != 0) && en && (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/wb_xbar_decoder.sv
// Wishbone 1-master to N-slave router with registered slave selection,
// decode-error response and per-transfer timeout with error status capture.
module wb_xbar_decoder
    import wb_xbar_pkg::*;
#(
    parameter int N_SLAVES     = 3,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter logic [ADDR_W-1:0] SLV_BASE [N_SLAVES] = '{32'h00000000, 32'h00100000, 32'h10000000},
    parameter logic [ADDR_W-1:0] SLV_MASK [N_SLAVES] = '{32'hFFF00000, 32'hFFFFFFFF, 32'hFFFFFFF8},
    parameter int TIMEOUT_CYC  = 1024,
    parameter bit UNMAPPED_ACK = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          cpu_ADR,
    input  logic [DATA_W-1:0]          cpu_DAT_O,
    input  logic                       cpu_WE,
    input  logic                       cpu_CYC,
    input  logic                       cpu_STB,
    output logic [DATA_W-1:0]          cpu_DAT_I,
    output logic                       cpu_ACK,
    output logic                       cpu_ERR,
    output logic [ADDR_W-1:0]          s_ADR,
    output logic [DATA_W-1:0]          s_DAT_O,
    output logic                       s_WE,
    output logic [N_SLAVES-1:0]        s_CYC,
    output logic [N_SLAVES-1:0]        s_STB,
    input  logic [N_SLAVES*DATA_W-1:0] s_DAT_I,
    input  logic [N_SLAVES-1:0]        s_ACK,
    output logic                       err_valid,
    output logic                       err_timeout,
    output logic [ADDR_W-1:0]          err_addr,
    input  logic                       err_clr
);

    state_t              state_reg, state_next;
    logic [3:0]          sel_reg;
    logic [ADDR_W-1:0]   adr_reg;
    logic                err_valid_reg, err_timeout_reg;
    logic [ADDR_W-1:0]   err_addr_reg;

    addr_arr_t           base_pad, mask_pad;
    match_t              match;
    logic [N_SLAVES-1:0] sel_oh;
    logic                sel_ack;
    logic [DATA_W-1:0]   dat_masked [N_SLAVES];
    logic [DATA_W-1:0]   rd_mux;
    logic                expire;
    logic                err_set, err_is_to;

    // Broadcast paths go straight through to every slave.
    assign s_ADR   = cpu_ADR;
    assign s_DAT_O = cpu_DAT_O;
    assign s_WE    = cpu_WE;

    // Widen the address map to the helper's fixed table size.
    for (genvar gi = 0; gi < MAX_SLAVES; gi++) begin : g_pad
        if (gi < N_SLAVES) begin : g_used
            assign base_pad[gi] = MAX_ADDR_W'(SLV_BASE[gi]);
            assign mask_pad[gi] = MAX_ADDR_W'(SLV_MASK[gi]);
        end else begin : g_unused
            assign base_pad[gi] = '1;
            assign mask_pad[gi] = '0;
        end
    end

    assign match = match_idx(MAX_ADDR_W'(cpu_ADR), base_pad, mask_pad);

    // One-hot view of the latched selection drives the strobe and return muxes.
    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_sel
        assign sel_oh[gi]     = (sel_reg == 4'(gi));
        assign dat_masked[gi] = sel_oh[gi] ? s_DAT_I[gi*DATA_W +: DATA_W] : '0;
    end

    assign sel_ack = |(s_ACK & sel_oh);

    // OR-reduce the masked slave read buses into the selected word.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            rd_mux = rd_mux | dat_masked[i];
        end
    end

    wb_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_reg != ACTIVE),
        .en     (state_reg == ACTIVE),
        .expire (expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: abort on CYC drop, ACK beats a same-cycle timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cpu_CYC && cpu_STB) begin
                    state_next = match.hit ? ACTIVE : DECERR;
                end
            end
            ACTIVE: begin
                if (!cpu_CYC || sel_ack) begin
                    state_next = IDLE;
                end else if (expire) begin
                    state_next = TOERR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: route only in ACTIVE, single-cycle responses otherwise.
    always_comb begin
        s_CYC     = '0;
        s_STB     = '0;
        cpu_ACK   = 1'b0;
        cpu_ERR   = 1'b0;
        cpu_DAT_I = '0;
        err_set   = 1'b0;
        err_is_to = 1'b0;
        case (state_reg)
            ACTIVE: begin
                s_CYC     = sel_oh & {N_SLAVES{cpu_CYC}};
                s_STB     = sel_oh & {N_SLAVES{cpu_CYC & cpu_STB}};
                cpu_ACK   = sel_ack;
                cpu_DAT_I = rd_mux;
            end
            DECERR: begin
                if (UNMAPPED_ACK) begin
                    cpu_ACK = 1'b1;
                end else begin
                    cpu_ERR = 1'b1;
                    err_set = 1'b1;
                end
            end
            TOERR: begin
                cpu_ERR   = 1'b1;
                err_set   = 1'b1;
                err_is_to = 1'b1;
            end
            default: ;
        endcase
    end

    // Latch selection and the faulting-address candidate at the start of a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_reg <= '0;
            adr_reg <= '0;
        end else if (state_reg == IDLE && cpu_CYC && cpu_STB) begin
            sel_reg <= match.idx;
            adr_reg <= cpu_ADR;
        end
    end

    // Sticky error status; a clear wins over a simultaneous new error.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid_reg   <= 1'b0;
            err_timeout_reg <= 1'b0;
            err_addr_reg    <= '0;
        end else begin
            if (err_set) begin
                err_timeout_reg <= err_is_to;
                err_addr_reg    <= adr_reg;
            end
            if (err_clr) begin
                err_valid_reg <= 1'b0;
            end else if (err_set) begin
                err_valid_reg <= 1'b1;
            end
        end
    end

    assign err_valid   = err_valid_reg;
    assign err_timeout = err_timeout_reg;
    assign err_addr    = err_addr_reg;

endmodule

// File: tb/tb_wb_xbar_decoder.sv
// Bench for wb_xbar_decoder: vector table, hand-written corner sequences and
// a randomized run against a transfer-level reference model.
module tb_wb_xbar_decoder;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst, err_clr;
    logic [31:0] cpu_ADR, cpu_DAT_O;
    logic        cpu_WE, cpu_CYC, cpu_STB;
    logic [95:0] s_DAT_I;
    logic [2:0]  s_ACK;

    logic [31:0] a_dat, a_sadr, a_sdato, a_eaddr;
    logic        a_ack, a_err, a_swe, a_ev, a_et;
    logic [2:0]  a_scyc, a_sstb;
    logic [31:0] u_dat, u_sadr, u_sdato, u_eaddr;
    logic        u_ack, u_err, u_swe, u_ev, u_et;
    logic [2:0]  u_scyc, u_sstb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_xbar_decoder #(.TIMEOUT_CYC(TMO), .UNMAPPED_ACK(1'b0)) dut (
        .clk(clk), .rst(rst), .cpu_ADR(cpu_ADR), .cpu_DAT_O(cpu_DAT_O), .cpu_WE(cpu_WE),
        .cpu_CYC(cpu_CYC), .cpu_STB(cpu_STB), .cpu_DAT_I(a_dat), .cpu_ACK(a_ack),
        .cpu_ERR(a_err), .s_ADR(a_sadr), .s_DAT_O(a_sdato), .s_WE(a_swe), .s_CYC(a_scyc),
        .s_STB(a_sstb), .s_DAT_I(s_DAT_I), .s_ACK(s_ACK), .err_valid(a_ev),
        .err_timeout(a_et), .err_addr(a_eaddr), .err_clr(err_clr));

    wb_xbar_decoder #(.TIMEOUT_CYC(TMO), .UNMAPPED_ACK(1'b1)) dut_u (
        .clk(clk), .rst(rst), .cpu_ADR(cpu_ADR), .cpu_DAT_O(cpu_DAT_O), .cpu_WE(cpu_WE),
        .cpu_CYC(cpu_CYC), .cpu_STB(cpu_STB), .cpu_DAT_I(u_dat), .cpu_ACK(u_ack),
        .cpu_ERR(u_err), .s_ADR(u_sadr), .s_DAT_O(u_sdato), .s_WE(u_swe), .s_CYC(u_scyc),
        .s_STB(u_sstb), .s_DAT_I(s_DAT_I), .s_ACK(s_ACK), .err_valid(u_ev),
        .err_timeout(u_et), .err_addr(u_eaddr), .err_clr(err_clr));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        cyc, stb, we;
        logic [31:0] adr, wdat;
        logic [2:0]  ack;
        logic [2:0]  e_stb;
        logic        e_ack, e_err;
        logic [31:0] e_dat;
        logic        eu_ack, eu_err;
        string       tag;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic cyc, stb, we, input logic [31:0] adr, wdat,
                       input logic [2:0] ack, e_stb, input logic e_ack, e_err,
                       input logic [31:0] e_dat, input logic eu_ack, eu_err, input string tag);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.we = we; v.adr = adr; v.wdat = wdat; v.ack = ack;
        v.e_stb = e_stb; v.e_ack = e_ack; v.e_err = e_err; v.e_dat = e_dat;
        v.eu_ack = eu_ack; v.eu_err = eu_err; v.tag = tag;
        tbl.push_back(v);
    endtask

    task automatic drive_idle();
        cpu_CYC = 1'b0; cpu_STB = 1'b0; cpu_WE = 1'b0; s_ACK = 3'b000;
    endtask

    task automatic req(input logic [31:0] adr);
        cpu_CYC = 1'b1; cpu_STB = 1'b1; cpu_ADR = adr;
    endtask

    // Address map written as plain address ranges.
    function automatic int ref_decode(input logic [31:0] a);
        if (a <= 32'h000FFFFF) return 0;
        if (a == 32'h00100000) return 1;
        if (a >= 32'h10000000 && a <= 32'h10000007) return 2;
        return -1;
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 9))
            0: return 32'h00000040;
            1: return 32'h000FFFFC;
            2: return 32'h00100000;
            3: return 32'h00100004;
            4: return 32'h10000000;
            5: return 32'h10000007;
            6: return 32'h10000008;
            7: return 32'h20000000;
            8: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n_stb;
        bit saw_err;
        // reference model state
        bit          m_busy;
        int          m_tgt, m_age, m_pend;
        logic [31:0] m_addr;
        bit          m_ev, m_et, mu_ev, mu_et;
        logic [31:0] m_ea, mu_ea;

        rst = 1'b1; err_clr = 1'b0; cpu_ADR = '0; cpu_DAT_O = '0;
        drive_idle();
        s_DAT_I = {32'h22220002, 32'h11110001, 32'hDEADBEEF};

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #2;
        chk("rst_s_stb", a_sstb, 3'b000);
        chk("rst_s_cyc", a_scyc, 3'b000);
        chk("rst_ack", a_ack, 1'b0);
        chk("rst_err", a_err, 1'b0);
        chk("rst_dat", a_dat, 32'h0);
        chk("rst_err_valid", a_ev, 1'b0);
        chk("rst_err_timeout", a_et, 1'b0);
        chk("rst_err_addr", a_eaddr, 32'h0);
        $display("reset checked");
        rst = 1'b0;

        // ---------------- vector table ----------------
        //   cyc  stb  we   adr           wdat   ack     e_stb   eack eerr e_dat         uack uerr
        add(0, 0, 0, 32'h00000000, 32'h0,  3'b000, 3'b000, 0, 0, 32'h00000000, 0, 0, "idle");
        add(1, 1, 0, 32'h00000040, 32'h0,  3'b000, 3'b000, 0, 0, 32'h00000000, 0, 0, "rd_req");
        add(1, 1, 0, 32'h00000040, 32'h0,  3'b000, 3'b001, 0, 0, 32'hDEADBEEF, 0, 0, "rd_stb");
        add(1, 1, 0, 32'h00000040, 32'h0,  3'b000, 3'b001, 0, 0, 32'hDEADBEEF, 0, 0, "rd_wait");
        add(1, 1, 0, 32'h00000040, 32'h0,  3'b001, 3'b001, 1, 0, 32'hDEADBEEF, 1, 0, "rd_ack");
        add(0, 0, 0, 32'h00000040, 32'h0,  3'b000, 3'b000, 0, 0, 32'h00000000, 0, 0, "rd_done");
        add(1, 1, 1, 32'h10000004, 32'h55, 3'b000, 3'b000, 0, 0, 32'h00000000, 0, 0, "wr_req");
        add(1, 1, 1, 32'h10000004, 32'h55, 3'b001, 3'b100, 0, 0, 32'h22220002, 0, 0, "wr_other_ack");
        add(1, 1, 1, 32'h10000004, 32'h55, 3'b100, 3'b100, 1, 0, 32'h22220002, 1, 0, "wr_ack");
        add(0, 0, 0, 32'h10000004, 32'h0,  3'b000, 3'b000, 0, 0, 32'h00000000, 0, 0, "wr_done");
        add(1, 1, 0, 32'h20000000, 32'h0,  3'b000, 3'b000, 0, 0, 32'h00000000, 0, 0, "um_req");
        add(1, 1, 0, 32'h20000000, 32'h0,  3'b111, 3'b000, 0, 1, 32'h00000000, 1, 0, "um_resp");
        add(0, 0, 0, 32'h20000000, 32'h0,  3'b000, 3'b000, 0, 0, 32'h00000000, 0, 0, "um_done");

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            cpu_CYC = tbl[i].cyc; cpu_STB = tbl[i].stb; cpu_WE = tbl[i].we;
            cpu_ADR = tbl[i].adr; cpu_DAT_O = tbl[i].wdat; s_ACK = tbl[i].ack;
            #2;
            chk({tbl[i].tag, "_s_stb"}, a_sstb, tbl[i].e_stb);
            chk({tbl[i].tag, "_s_cyc"}, a_scyc, tbl[i].e_stb);
            chk({tbl[i].tag, "_ack"}, a_ack, tbl[i].e_ack);
            chk({tbl[i].tag, "_err"}, a_err, tbl[i].e_err);
            chk({tbl[i].tag, "_dat"}, a_dat, tbl[i].e_dat);
            chk({tbl[i].tag, "_s_we"}, a_swe, tbl[i].we);
            chk({tbl[i].tag, "_s_dat_o"}, a_sdato, tbl[i].wdat);
            chk({tbl[i].tag, "_s_adr"}, a_sadr, tbl[i].adr);
            chk({tbl[i].tag, "_u_ack"}, u_ack, tbl[i].eu_ack);
            chk({tbl[i].tag, "_u_err"}, u_err, tbl[i].eu_err);
            $display("vec %0d %s: s_stb=%b ack=%b err=%b dat=%h u_ack=%b", i, tbl[i].tag,
                     a_sstb, a_ack, a_err, a_dat, u_ack);
        end
        chk("um_err_valid", a_ev, 1'b1);
        chk("um_err_addr", a_eaddr, 32'h20000000);
        chk("um_err_timeout", a_et, 1'b0);
        chk("um_u_err_valid", u_ev, 1'b0);

        // ---------------- timeout on slave 1 ----------------
        @(negedge clk);
        err_clr = 1'b1; req(32'h00100000);
        n_stb = 0; saw_err = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            err_clr = 1'b0;
            #2;
            if (a_sstb == 3'b010) n_stb++;
            if (a_err) begin
                saw_err = 1'b1;
                chk("to_err_s_stb", a_sstb, 3'b000);
                chk("to_err_dat", a_dat, 32'h0);
                break;
            end
        end
        chk("to_stb_cycles", n_stb, TMO);
        chk("to_err_seen", saw_err, 1'b1);
        @(negedge clk);
        drive_idle();
        #2;
        chk("to_err_valid", a_ev, 1'b1);
        chk("to_err_timeout", a_et, 1'b1);
        chk("to_err_addr", a_eaddr, 32'h00100000);
        chk("to_u_err_valid", u_ev, 1'b1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #2;
        chk("clr_err_valid", a_ev, 1'b0);
        $display("seq timeout: stb_cycles=%0d err_seen=%0d", n_stb, saw_err);

        // ---------------- ACK in the expiry cycle ----------------
        @(negedge clk);
        req(32'h00100000);
        for (int i = 1; i <= TMO; i++) begin
            @(negedge clk);
            if (i == TMO) s_ACK = 3'b010;
            #2;
            if (i == TMO) begin
                chk("exp_ack", a_ack, 1'b1);
                chk("exp_err", a_err, 1'b0);
                chk("exp_dat", a_dat, 32'h11110001);
            end
        end
        @(negedge clk);
        drive_idle();
        #2;
        chk("exp_after_err", a_err, 1'b0);
        chk("exp_after_stb", a_sstb, 3'b000);
        chk("exp_after_err_valid", a_ev, 1'b0);
        $display("seq expiry-ack done");

        // ---------------- CYC drop, address change during ACTIVE ----------------
        @(negedge clk); req(32'h00000040);
        @(negedge clk); #2; chk("drop_stb0", a_sstb, 3'b001);
        @(negedge clk); cpu_ADR = 32'h10000000; #2; chk("adrchg_stb", a_sstb, 3'b001);
        @(negedge clk); cpu_CYC = 1'b0; cpu_STB = 1'b0; #2;
        chk("drop_s_stb", a_sstb, 3'b000);
        chk("drop_s_cyc", a_scyc, 3'b000);
        @(negedge clk); req(32'h00100000); #2; chk("new_idle_stb", a_sstb, 3'b000);
        @(negedge clk); #2; chk("new_sel1_stb", a_sstb, 3'b010);
        @(negedge clk); s_ACK = 3'b010; #2;
        chk("new_sel1_ack", a_ack, 1'b1);
        chk("new_sel1_dat", a_dat, 32'h11110001);
        @(negedge clk); drive_idle(); #2;
        chk("drop_no_err", a_ev, 1'b0);
        $display("seq cyc-drop done");

        // ---------------- reset mid-transfer ----------------
        @(negedge clk); req(32'h20000000);
        @(negedge clk);
        @(negedge clk); drive_idle(); #2; chk("pre_rst_err_valid", a_ev, 1'b1);
        @(negedge clk); req(32'h00000040);
        @(negedge clk); #2; chk("pre_rst_stb", a_sstb, 3'b001);
        @(negedge clk); rst = 1'b1; s_ACK = 3'b001;
        @(negedge clk); #2;
        chk("mid_rst_s_stb", a_sstb, 3'b000);
        chk("mid_rst_s_cyc", a_scyc, 3'b000);
        chk("mid_rst_ack", a_ack, 1'b0);
        chk("mid_rst_err", a_err, 1'b0);
        chk("mid_rst_dat", a_dat, 32'h0);
        chk("mid_rst_err_valid", a_ev, 1'b0);
        chk("mid_rst_err_addr", a_eaddr, 32'h0);
        drive_idle();
        @(negedge clk); rst = 1'b0;
        $display("seq mid-reset done");

        // ---------------- randomized run against the model ----------------
        m_busy = 0; m_tgt = 0; m_age = 0; m_pend = 0; m_addr = '0;
        m_ev = 0; m_et = 0; m_ea = '0; mu_ev = 0; mu_et = 0; mu_ea = '0;
        for (int c = 0; c < 600; c++) begin
            logic [2:0]  e_stb, e_cyc;
            logic        e_ack, e_err, eu_ack, eu_err;
            logic [31:0] e_dat;
            int          t;
            @(negedge clk);
            cpu_CYC   = ($urandom_range(0, 99) < 88);
            cpu_STB   = cpu_CYC && ($urandom_range(0, 3) != 0);
            cpu_WE    = 1'($urandom_range(0, 1));
            cpu_DAT_O = $urandom;
            if ($urandom_range(0, 9) < 3) cpu_ADR = pick_addr();
            s_ACK     = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                         ($urandom_range(0, 3) == 0)};
            s_DAT_I   = {$urandom, $urandom, $urandom};
            err_clr   = ($urandom_range(0, 19) == 0);
            #2;
            e_stb = '0; e_cyc = '0; e_ack = 0; e_err = 0; e_dat = '0; eu_ack = 0; eu_err = 0;
            if (m_pend == 1) begin
                e_err = 1; eu_ack = 1;
            end else if (m_pend == 2) begin
                e_err = 1; eu_err = 1;
            end else if (m_busy) begin
                e_cyc[m_tgt] = cpu_CYC;
                e_stb[m_tgt] = cpu_CYC & cpu_STB;
                e_ack        = s_ACK[m_tgt];
                eu_ack       = s_ACK[m_tgt];
                e_dat        = s_DAT_I[m_tgt*32 +: 32];
            end
            chk("rnd_s_stb", a_sstb, e_stb);
            chk("rnd_s_cyc", a_scyc, e_cyc);
            chk("rnd_ack", a_ack, e_ack);
            chk("rnd_err", a_err, e_err);
            chk("rnd_dat", a_dat, e_dat);
            chk("rnd_ack_and_err", a_ack & a_err, 1'b0);
            chk("rnd_err_valid", a_ev, m_ev);
            chk("rnd_err_timeout", a_et, m_et);
            chk("rnd_err_addr", a_eaddr, m_ea);
            chk("rnd_u_s_stb", u_sstb, e_stb);
            chk("rnd_u_ack", u_ack, eu_ack);
            chk("rnd_u_err", u_err, eu_err);
            chk("rnd_u_err_valid", u_ev, mu_ev);
            chk("rnd_u_err_addr", u_eaddr, mu_ea);

            // advance the model to the next cycle
            if (m_pend != 0) begin
                m_ev = 1; m_et = (m_pend == 2); m_ea = m_addr;
                if (m_pend == 2) begin
                    mu_ev = 1; mu_et = 1; mu_ea = m_addr;
                end
                $display("rnd xfer adr=%h result=%s", m_addr, (m_pend == 2) ? "timeout" : "unmapped");
                m_pend = 0;
            end else if (m_busy) begin
                m_age++;
                if (!cpu_CYC) begin
                    m_busy = 0;
                    $display("rnd xfer adr=%h slave=%0d result=abort", m_addr, m_tgt);
                end else if (s_ACK[m_tgt]) begin
                    m_busy = 0;
                    $display("rnd xfer adr=%h slave=%0d result=ack", m_addr, m_tgt);
                end else if (m_age == TMO) begin
                    m_busy = 0; m_pend = 2;
                end
            end else if (cpu_CYC && cpu_STB) begin
                m_addr = cpu_ADR;
                t = ref_decode(cpu_ADR);
                if (t < 0) begin
                    m_pend = 1;
                end else begin
                    m_busy = 1; m_tgt = t; m_age = 0;
                end
            end
            if (err_clr) begin
                m_ev = 0; mu_ev = 0;
            end
        end
        err_clr = 1'b0;
        drive_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
